// File: rtl/jtframe_pocket_dwnld.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_pocket_dwnld
// Brief   : Buffers Pocket bridge word writes and replays them as paced bytes.
// Revision: 1.0
// ============================================================================
module jtframe_pocket_dwnld #(
  parameter logic [3:0] ADDR_BASE = 4'h0,
  parameter int         GAP       = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bridge_endian_little,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_wr_data,
  input  logic        dataslot_allcomplete,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic        ioctl_wr,
  output logic        downloading,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BYTE = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [3:0] c_gap_last = 4'(GAP - 1);

  state_t      r_state, w_next;
  logic [22:0] r_fa [4];
  logic [31:0] r_fd [4];
  logic        r_fe [4];
  logic [1:0]  r_wptr, r_rptr;
  logic [2:0]  r_cnt;
  logic [31:0] r_sr;
  logic [1:0]  r_bcnt;
  logic [3:0]  r_wcnt;
  logic        r_ac_prev, r_ac_latch;

  logic        w_match, w_empty, w_full, w_push, w_pop, w_adv, w_wait_done;
  logic [31:0] w_raw, w_word;
  logic        w_unused;

  assign w_unused    = ^{bridge_addr[27:25], bridge_addr[1:0]};
  assign w_match     = bridge_addr[31:28] == ADDR_BASE;
  assign w_empty     = r_cnt == 3'd0;
  assign w_full      = r_cnt == 3'd4;
  assign w_push      = bridge_wr & w_match & ~w_full;
  assign w_pop       = (r_state == IDLE) & ~w_empty;
  assign w_wait_done = (r_state == WAIT) & (r_wcnt == c_gap_last);
  assign w_adv       = w_wait_done & (r_bcnt != 2'd3);
  assign ioctl_wr    = r_state == BYTE;

  // The shift register always holds the word in emission order (MSB first)
  assign w_raw  = r_fd[r_rptr];
  assign w_word = r_fe[r_rptr] ? {w_raw[7:0], w_raw[15:8], w_raw[23:16], w_raw[31:24]}
                               : w_raw;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_next = BYTE;
      BYTE:    w_next = WAIT;
      WAIT:    if (w_wait_done) w_next = (r_bcnt == 2'd3) ? IDLE : BYTE;
      default: w_next = IDLE;
    endcase
  end

  // Storage has no reset: only pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wptr] <= bridge_addr[24:2];
      r_fd[r_wptr] <= bridge_wr_data;
      r_fe[r_wptr] <= bridge_endian_little;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_cnt      <= 3'd0;
      r_sr       <= 32'd0;
      r_bcnt     <= 2'd0;
      r_wcnt     <= 4'd0;
      ioctl_addr <= 25'd0;
      ioctl_dout <= 8'd0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= (r_state == WAIT) ? r_wcnt + 4'd1 : 4'd0;
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
      if (w_pop) begin
        r_bcnt     <= 2'd0;
        r_sr       <= w_word;
        ioctl_dout <= w_word[31:24];
        ioctl_addr <= {r_fa[r_rptr], 2'b00};
      end else if (w_adv) begin
        r_bcnt     <= r_bcnt + 2'd1;
        r_sr       <= {r_sr[23:0], 8'h00};
        ioctl_dout <= r_sr[23:16];
        ioctl_addr <= ioctl_addr + 25'd1;
      end
    end
  end

  // A new push keeps the download alive even if completion is pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      downloading <= 1'b0;
      ovf         <= 1'b0;
      r_ac_prev   <= 1'b0;
      r_ac_latch  <= 1'b0;
    end else begin
      r_ac_prev <= dataslot_allcomplete;
      if (bridge_wr && w_match && w_full) ovf <= 1'b1;
      if (w_push) begin
        downloading <= 1'b1;
      end else if (r_ac_latch && w_empty && r_state == IDLE) begin
        downloading <= 1'b0;
        r_ac_latch  <= 1'b0;
      end
      if (downloading && dataslot_allcomplete && !r_ac_prev) r_ac_latch <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_pocket_dwnld.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtframe_pocket_dwnld
// Brief   : Directed self-checking bench for jtframe_pocket_dwnld.
// Revision: 1.0
// ============================================================================
module tb_jtframe_pocket_dwnld;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bridge_endian_little = 1'b0;
  logic [31:0] bridge_addr = 32'd0;
  logic        bridge_wr = 1'b0;
  logic [31:0] bridge_wr_data = 32'd0;
  logic        dataslot_allcomplete = 1'b0;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        downloading;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int ecnt     = 0;
  int wr_edge  = 0;

  // Pulse log: edge at which the pulse is sampled, address, data
  int          pe[$];
  logic [24:0] pa[$];
  logic [7:0]  pd[$];

  jtframe_pocket_dwnld #(.ADDR_BASE(4'h0), .GAP(GAP)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .bridge_endian_little(bridge_endian_little),
    .bridge_addr         (bridge_addr),
    .bridge_wr           (bridge_wr),
    .bridge_wr_data      (bridge_wr_data),
    .dataslot_allcomplete(dataslot_allcomplete),
    .ioctl_addr          (ioctl_addr),
    .ioctl_dout          (ioctl_dout),
    .ioctl_wr            (ioctl_wr),
    .downloading         (downloading),
    .ovf                 (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (ioctl_wr) begin
      pe.push_back(ecnt + 1);
      pa.push_back(ioctl_addr);
      pd.push_back(ioctl_dout);
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    pe.delete();
    pa.delete();
    pd.delete();
  endtask

  // Called at #1 after an edge; the write is sampled at the next edge
  task automatic bwrite(input logic [31:0] a, input logic [31:0] d, input logic e);
    bridge_addr          = a;
    bridge_wr_data       = d;
    bridge_endian_little = e;
    bridge_wr            = 1'b1;
    @(posedge clk);
    #1;
    wr_edge   = ecnt;
    bridge_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bridge_wr = 1'b0;
    dataslot_allcomplete = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    clear_log();
    cycles(1);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (ioctl_wr !== 1'b0) $display("FAIL rst_wr: got %h exp 0", ioctl_wr); else n_pass++;
    n_checks++; if (ioctl_addr !== 25'd0) $display("FAIL rst_addr: got %h exp 0", ioctl_addr); else n_pass++;
    n_checks++; if (ioctl_dout !== 8'd0) $display("FAIL rst_dout: got %h exp 0", ioctl_dout); else n_pass++;
    n_checks++; if (downloading !== 1'b0) $display("FAIL rst_dl: got %h exp 0", downloading); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %h exp 0", ovf); else n_pass++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycles(6);
    n_checks++; if (pe.size() !== 0) $display("FAIL rst_idle_pulses: got %0d exp 0", pe.size()); else n_pass++;
  endtask

  task automatic test_big_endian();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    bwrite(32'h0000_0010, 32'h1122_3344, 1'b0);
    cycles(20);
    n_checks++; if (pe.size() !== 4) $display("FAIL be_count: got %0d exp 4", pe.size()); else n_pass++;
    for (int i = 0; i < 4 && i < pe.size(); i++) begin
      n_checks++; if (pe[i] !== wr_edge + 2 + 3 * i) $display("FAIL be_time%0d: got %0d exp %0d", i, pe[i], wr_edge + 2 + 3 * i); else n_pass++;
      n_checks++; if (pa[i] !== 25'h10 + 25'(i)) $display("FAIL be_addr%0d: got %h exp %h", i, pa[i], 25'h10 + 25'(i)); else n_pass++;
      n_checks++; if (pd[i] !== exp_b[i]) $display("FAIL be_data%0d: got %h exp %h", i, pd[i], exp_b[i]); else n_pass++;
    end
    n_checks++; if (ioctl_addr !== 25'h13 || ioctl_dout !== 8'h44) $display("FAIL be_hold: got %h/%h exp 13/44", ioctl_addr, ioctl_dout); else n_pass++;
  endtask

  task automatic test_little_endian();
    logic [7:0] exp_b [4];
    exp_b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    clear_log();
    bwrite(32'h0000_0103, 32'hAABB_CCDD, 1'b1);
    cycles(20);
    n_checks++; if (pe.size() !== 4) $display("FAIL le_count: got %0d exp 4", pe.size()); else n_pass++;
    for (int i = 0; i < 4 && i < pe.size(); i++) begin
      n_checks++; if (pa[i] !== 25'h100 + 25'(i)) $display("FAIL le_addr%0d: got %h exp %h", i, pa[i], 25'h100 + 25'(i)); else n_pass++;
      n_checks++; if (pd[i] !== exp_b[i]) $display("FAIL le_data%0d: got %h exp %h", i, pd[i], exp_b[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    clear_log();
    bwrite(32'h0000_0200, 32'h0102_0304, 1'b0);
    n0 = wr_edge;
    bwrite(32'h0000_0204, 32'h0506_0708, 1'b0);
    cycles(35);
    n_checks++; if (pe.size() !== 8) $display("FAIL b2b_count: got %0d exp 8", pe.size()); else n_pass++;
    if (pe.size() == 8) begin
      n_checks++; if (pe[4] !== pe[3] + GAP + 2) $display("FAIL b2b_gap: got %0d exp %0d", pe[4] - pe[3], GAP + 2); else n_pass++;
      n_checks++; if (pe[7] !== n0 + 2 + 3 * 3 + 4 + 3 * 3) $display("FAIL b2b_last: got %0d exp %0d", pe[7], n0 + 24); else n_pass++;
      n_checks++; if (pa[5] !== 25'h205 || pd[5] !== 8'h06) $display("FAIL b2b_byte5: got %h/%h exp 205/06", pa[5], pd[5]); else n_pass++;
    end
    n_checks++; if (ovf !== 1'b0) $display("FAIL b2b_ovf: got %h exp 0", ovf); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int w = 0; w < 5; w++) bwrite(32'(w * 4), 32'hA0A0_A000 + 32'(w), 1'b0);
    n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_early: got %h exp 0", ovf); else n_pass++;
    bwrite(32'h0000_0014, 32'hA0A0_A005, 1'b0);
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %h exp 1", ovf); else n_pass++;
    cycles(100);
    n_checks++; if (pe.size() !== 20) $display("FAIL ovf_count: got %0d exp 20", pe.size()); else n_pass++;
    for (int w = 0; w < 5 && pe.size() == 20; w++) begin
      n_checks++; if (pa[4 * w + 3] !== 25'(4 * w + 3)) $display("FAIL ovf_addr%0d: got %h exp %h", w, pa[4 * w + 3], 4 * w + 3); else n_pass++;
      n_checks++; if (pd[4 * w + 3] !== 8'(w)) $display("FAIL ovf_data%0d: got %h exp %h", w, pd[4 * w + 3], w); else n_pass++;
    end
    bwrite(32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    cycles(20);
    n_checks++; if (pe.size() !== 24) $display("FAIL ovf_after_count: got %0d exp 24", pe.size()); else n_pass++;
    if (pe.size() == 24) begin
      n_checks++; if (pa[20] !== 25'h40 || pd[20] !== 8'hDE) $display("FAIL ovf_after_byte: got %h/%h exp 40/de", pa[20], pd[20]); else n_pass++;
    end
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %h exp 1", ovf); else n_pass++;
  endtask

  task automatic test_filter();
    do_reset();
    bwrite(32'h1000_0000, 32'h5555_5555, 1'b0);
    cycles(10);
    n_checks++; if (pe.size() !== 0) $display("FAIL filt_pulses: got %0d exp 0", pe.size()); else n_pass++;
    n_checks++; if (downloading !== 1'b0) $display("FAIL filt_dl: got %h exp 0", downloading); else n_pass++;
  endtask

  task automatic test_completion();
    int d_edge;
    bit seen;
    do_reset();
    for (int w = 0; w < 3; w++) bwrite(32'h0000_0300 + 32'(w * 4), 32'h1020_3040 + 32'(w), 1'b0);
    dataslot_allcomplete = 1'b1;
    cycles(1);
    dataslot_allcomplete = 1'b0;
    n_checks++; if (downloading !== 1'b1) $display("FAIL cmp_dl_busy: got %h exp 1", downloading); else n_pass++;
    d_edge = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycles(1);
      if (!downloading) begin
        seen   = 1'b1;
        d_edge = ecnt;
      end
    end
    n_checks++; if (!seen) $display("FAIL cmp_timeout: got busy exp idle within 100 cycles"); else n_pass++;
    n_checks++; if (pe.size() !== 12) $display("FAIL cmp_count: got %0d exp 12", pe.size()); else n_pass++;
    if (pe.size() == 12) begin
      n_checks++; if (d_edge !== pe[11] + GAP + 1) $display("FAIL cmp_clear_time: got %0d exp %0d", d_edge, pe[11] + GAP + 1); else n_pass++;
    end
    dataslot_allcomplete = 1'b1;
    cycles(1);
    dataslot_allcomplete = 1'b0;
    cycles(5);
    n_checks++; if (downloading !== 1'b0) $display("FAIL cmp_idle_edge: got %h exp 0", downloading); else n_pass++;
    // The edge seen while idle must not end the next download early
    bwrite(32'h0000_0400, 32'h0, 1'b0);
    cycles(20);
    n_checks++; if (downloading !== 1'b1) $display("FAIL cmp_ignored_edge: got %h exp 1", downloading); else n_pass++;
  endtask

  task automatic test_midword_reset();
    bit got2;
    do_reset();
    bwrite(32'h0000_0500, 32'h9988_7766, 1'b0);
    got2 = 1'b0;
    for (int i = 0; i < 20 && !got2; i++) begin
      cycles(1);
      if (pe.size() >= 2) got2 = 1'b1;
    end
    n_checks++; if (!got2) $display("FAIL mid_two_bytes: got %0d exp 2 pulses", pe.size()); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({ioctl_wr, ioctl_addr, ioctl_dout, downloading, ovf} !== 36'd0)
      $display("FAIL mid_async_clear: got %h/%h/%h/%h/%h exp all 0", ioctl_wr, ioctl_addr, ioctl_dout, downloading, ovf);
    else n_pass++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycles(20);
    n_checks++; if (pe.size() !== 2) $display("FAIL mid_no_more: got %0d exp 2", pe.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_big_endian();
    test_little_endian();
    test_back_to_back();
    test_overflow();
    test_filter();
    test_completion();
    test_midword_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtframe_pocket_dwnld.md
JTFRAME_POCKET_DWNLD -- requirements
Module: jtframe_pocket_dwnld

Interface
REQ-001 Parameter ADDR_BASE, default 4'h0: the value bridge_addr[31:28] must equal for a write to count as download data.
REQ-002 Parameter GAP, default 2, legal range 1..15: the number of idle cycles between consecutive ioctl_wr pulses.
REQ-003 clk  in  1  single clock for the whole block; the bridge signals are already synchronous to it.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 bridge_endian_little  in  1  byte order of bridge_wr_data; 1 = little endian.
REQ-006 bridge_addr  in  32  byte address of the bridge write.
REQ-007 bridge_wr  in  1  one-cycle strobe that qualifies bridge_addr and bridge_wr_data.
REQ-008 bridge_wr_data  in  32  write data word.
REQ-009 dataslot_allcomplete  in  1  host indication that all data slots have been sent.
REQ-010 ioctl_addr  out  25  byte address of the current ioctl byte.
REQ-011 ioctl_dout  out  8  current ioctl byte.
REQ-012 ioctl_wr  out  1  one-cycle strobe that qualifies ioctl_addr and ioctl_dout.
REQ-013 downloading  out  1  high while a download is in progress.
REQ-014 ovf  out  1  sticky flag; set when a write is dropped because the FIFO is full.

Function
REQ-015 Accept: a bridge write is accepted when bridge_wr=1, bridge_addr[31:28]=ADDR_BASE and the FIFO is not full.
REQ-016 Push: an accepted write stores {bridge_addr[24:2],2'b00, bridge_wr_data, bridge_endian_little} in a 4-entry FIFO; bridge_addr[1:0] is ignored.
REQ-017 Drop: a matching write that arrives while the FIFO holds 4 entries is discarded and ovf is set; ovf stays set until reset.
REQ-018 Non-matching write: a bridge write whose bridge_addr[31:28] differs from ADDR_BASE is ignored and has no effect on any state.
REQ-019 Simultaneous push and pop: a push and a pop in the same cycle are both performed; the occupancy count is unchanged.
REQ-020 FSM states: IDLE, BYTE, WAIT.
REQ-021 IDLE: when the FIFO is not empty, pop one entry into the shift register, set the byte counter to 0 and go to BYTE; otherwise stay in IDLE.
REQ-022 BYTE: drive ioctl_wr=1 for exactly this one cycle, then go to WAIT.
REQ-023 WAIT: hold for GAP cycles; then go to BYTE if the counter is below 3 (incrementing the counter and advancing the byte), or to IDLE if the counter is 3.
REQ-024 Byte order: with endian bit 0, byte k (k=0..3) is data[31-8k:24-8k]; with endian bit 1, byte k is data[8k+7:8k].
REQ-025 Byte address: ioctl_addr = word address + k, computed modulo 2^25.
REQ-026 ioctl_addr and ioctl_dout are registered, change only on the cycle ioctl_wr rises, and hold until the next pulse.
REQ-027 Latency: for a write sampled at edge N with the FSM in IDLE and the FIFO empty, the first ioctl_wr is high during cycle N+2.
REQ-028 Pacing: a word produces exactly 4 pulses spaced GAP+1 cycles apart; the next word's first pulse follows GAP+2 cycles after the previous word's last pulse.
REQ-029 downloading: set on the cycle after the first accepted push.
REQ-030 A rising edge of dataslot_allcomplete is latched while downloading=1.
REQ-031 downloading clears when the latch is set, the FIFO is empty and the FSM is in IDLE; the latch clears at the same time.
REQ-032 A dataslot_allcomplete edge seen while downloading=0 is ignored.

Reset
REQ-033 When reset_n=0, asynchronously force: FIFO empty, FSM in IDLE, ioctl_wr=0, ioctl_addr=0, ioctl_dout=0, downloading=0, ovf=0, allcomplete latch=0.
REQ-034 Reset asserted mid-word aborts the word; the remaining bytes are never emitted.
REQ-035 After reset_n rises, no ioctl_wr occurs until a new write is accepted.

Verification
REQ-036 Big-endian word: addr 0x0000_0010, data 0x11223344, endian 0, GAP=2 -> pulses at N+2, N+5, N+8, N+11 carrying 0x11@0x10, 0x22@0x11, 0x33@0x12, 0x44@0x13.
REQ-037 Little-endian word: data 0xAABBCCDD at addr 0x0000_0103, endian 1 -> bytes 0xDD, 0xCC, 0xBB, 0xAA at addresses 0x100..0x103.
REQ-038 Overflow: 6 back-to-back matching writes -> the first (popped) word plus 4 queued words are emitted, 1 write is dropped, ovf=1; a later write is accepted normally and ovf stays 1.
REQ-039 Filtering: a write to 0x1000_0000 with ADDR_BASE=0 -> no ioctl_wr, downloading stays 0.
REQ-040 Completion: dataslot_allcomplete pulses while 2 words are still queued -> downloading stays 1 until the last byte's WAIT ends, then 0; a second allcomplete pulse while idle leaves downloading at 0.
REQ-041 Mid-word reset: reset_n is pulled low after the 2nd byte -> all outputs are 0 immediately; after release, no ioctl_wr occurs.
